// File: rtl/ksa_swap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ksa_swap_sequencer
//  Description : RC4 key-scheduling pass over the S-memory. For every i it
//                reads S[i], accumulates j = j + S[i] + key[i mod KEY_BYTES],
//                reads S[j] and writes the swapped pair back through one
//                synchronous single-port RAM channel.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters  : RAM_WIDTH  data/address width (bits)
//                RAM_SIZE   number of S entries, must be 2**RAM_WIDTH
//                KEY_BYTES  secret key length in bytes
//  Ports       : clk       rising-edge clock
//                reset     asynchronous active-low reset
//                start     level request, sampled in IDLE and DONE only
//                key       secret key, byte 0 in the MSBs, latched on start
//                ram_out   RAM read data, valid the cycle after its address
//                address   RAM address
//                ram_in    RAM write data
//                wren      RAM write enable
//                busy      high in every state except IDLE and DONE
//                finished  high only in DONE
//  Config      : `define KSA_SKIP_SELF_SWAP_EN to skip the j read and both
//                writes of any iteration whose new j equals i (3-cycle
//                iteration, no writes).
// ============================================================================
module ksa_swap_sequencer #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_SIZE  = 256,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic [RAM_WIDTH-1:0]   ram_out,
    output logic [RAM_WIDTH-1:0]   address,
    output logic [RAM_WIDTH-1:0]   ram_in,
    output logic                   wren,
    output logic                   busy,
    output logic                   finished
);

    localparam int                   KIDX_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [RAM_WIDTH-1:0] C_LAST_I = RAM_WIDTH'(RAM_SIZE - 1);
    localparam logic [KIDX_W-1:0]    C_LAST_K = KIDX_W'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD_I  = 4'd1,
        S_CAP_I = 4'd2,
        S_RD_J  = 4'd3,
        S_CAP_J = 4'd4,
        S_WR_I  = 4'd5,
        S_WR_J  = 4'd6,
        S_ADV   = 4'd7,   // self-swap shortcut: end-of-iteration with no write
        S_DONE  = 4'd8
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RAM_WIDTH-1:0]   r_i;
    logic [RAM_WIDTH-1:0]   r_j;
    logic [RAM_WIDTH-1:0]   r_si;
    logic [RAM_WIDTH-1:0]   r_sj;
    logic [KIDX_W-1:0]      r_kidx;
    logic [KEY_BYTES*8-1:0] r_key;
    logic [7:0]             w_keybyte;
    logic [RAM_WIDTH-1:0]   w_j_sum;
    logic                   w_last;

    // Key byte select by the wrapping index; byte 0 sits in the MSBs.
    always_comb begin
        w_keybyte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (r_kidx == KIDX_W'(k)) begin
                w_keybyte = r_key[(KEY_BYTES-1-k)*8 +: 8];
            end
        end
    end

    // Three-operand sum, valid in CAP_I when ram_out carries S[i].
    assign w_j_sum = r_j + ram_out + RAM_WIDTH'(w_keybyte);
    assign w_last  = (r_i == C_LAST_I);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        address     = '0;
        ram_in      = '0;
        wren        = 1'b0;
        busy        = 1'b1;
        finished    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_RD_I;
                end
            end
            S_RD_I: begin
                address     = r_i;
                w_state_nxt = S_CAP_I;
            end
            S_CAP_I: begin
`ifdef KSA_SKIP_SELF_SWAP_EN
                w_state_nxt = (w_j_sum == r_i) ? S_ADV : S_RD_J;
`else
                w_state_nxt = S_RD_J;
`endif
            end
            S_RD_J: begin
                address     = r_j;
                w_state_nxt = S_CAP_J;
            end
            S_CAP_J: begin
                w_state_nxt = S_WR_I;
            end
            // S[j] is already captured, so overwriting S[i] first is safe
            // even when i == j.
            S_WR_I: begin
                address     = r_i;
                ram_in      = r_sj;
                wren        = 1'b1;
                w_state_nxt = S_WR_J;
            end
            S_WR_J: begin
                address     = r_j;
                ram_in      = r_si;
                wren        = 1'b1;
                w_state_nxt = w_last ? S_DONE : S_RD_I;
            end
            S_ADV: begin
                w_state_nxt = w_last ? S_DONE : S_RD_I;
            end
            S_DONE: begin
                busy     = 1'b0;
                finished = 1'b1;
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i    <= '0;
            r_j    <= '0;
            r_si   <= '0;
            r_sj   <= '0;
            r_kidx <= '0;
            r_key  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i    <= '0;
                        r_j    <= '0;
                        r_kidx <= '0;
                        r_key  <= key;
                    end
                end
                S_CAP_I: begin
                    r_si <= ram_out;
                    r_j  <= w_j_sum;
                end
                S_CAP_J: begin
                    r_sj <= ram_out;
                end
                S_WR_J, S_ADV: begin
                    if (!w_last) begin
                        r_i    <= r_i + RAM_WIDTH'(1);
                        r_kidx <= (r_kidx == C_LAST_K) ? '0 : r_kidx + KIDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ksa_swap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ksa_swap_sequencer
//  Description : Self-checking bench for ksa_swap_sequencer. A bench-side
//                synchronous RAM holds S; an algorithm-level RC4 KSA model
//                produces the expected per-cycle bus trace and final S.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ksa_swap_sequencer;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       wren;
        logic       busy;
        logic       fin;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] key = '0;
    logic [7:0]  ram_out;
    logic [7:0]  address;
    logic [7:0]  ram_in;
    logic        wren;
    logic        busy;
    logic        finished;

    logic [7:0]  mem [256];
    logic [7:0]  model_s [256];
    logic        init_req = 1'b0;
    exp_t        tr[$];
    exp_t        exp_q[$];
    exp_t        cmp_e;
    exp_t        cmp_a;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          g_done  = 0;
    int          cyc_in_run = 0;

    ksa_swap_sequencer dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .key      (key),
        .ram_out  (ram_out),
        .address  (address),
        .ram_in   (ram_in),
        .wren     (wren),
        .busy     (busy),
        .finished (finished)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (init_req) begin
            for (int n = 0; n < 256; n++) mem[n] <= n[7:0];
        end else begin
            ram_out <= mem[address];
            if (wren) mem[address] <= ram_in;
        end
    end

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] d,
                                input logic w, input logic b, input logic f);
        exp_t e;
        e.addr = a; e.data = d; e.wren = w; e.busy = b; e.fin = f;
        return e;
    endfunction

    // Per-cycle comparison against the model trace.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_a = mk(address, ram_in, wren, busy, finished);
            cyc_in_run++;
            n_tests++;
            if (cmp_a !== cmp_e) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL bus cycle %0d: got addr=%h data=%h wren=%b busy=%b fin=%b, expected addr=%h data=%h wren=%b busy=%b fin=%b",
                             cyc_in_run, cmp_a.addr, cmp_a.data, cmp_a.wren, cmp_a.busy, cmp_a.fin,
                             cmp_e.addr, cmp_e.data, cmp_e.wren, cmp_e.busy, cmp_e.fin);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic init_identity();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    // RC4 KSA at algorithm level, emitting the expected bus activity per cycle.
    task automatic build_model(input logic [23:0] k);
        logic [7:0] j, si, sj, kb;
        tr.delete();
        for (int n = 0; n < 256; n++) model_s[n] = mem[n];
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            kb = k[(23 - 8*(i % 3)) -: 8];
            si = model_s[i];
            j  = j + si + kb;
            sj = model_s[j];
            tr.push_back(mk(i[7:0], 8'd0, 1'b0, 1'b1, 1'b0));
            tr.push_back(mk(8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
`ifdef KSA_SKIP_SELF_SWAP_EN
            if (j == i[7:0]) begin
                tr.push_back(mk(8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
                continue;
            end
`endif
            tr.push_back(mk(j, 8'd0, 1'b0, 1'b1, 1'b0));
            tr.push_back(mk(8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
            tr.push_back(mk(i[7:0], sj, 1'b1, 1'b1, 1'b0));
            tr.push_back(mk(j, si, 1'b1, 1'b1, 1'b0));
            model_s[i] = sj;
            model_s[j] = si;
        end
    endtask

    // One pass. drop_c: cycle in which start falls (<=0: four cycles into DONE).
    // kchg_c: cycle in which key changes to k2. rst_c: cycle of mid-run reset.
    task automatic run(input logic [23:0] k, input int drop_c, input int kchg_c,
                       input logic [23:0] k2, input int rst_c, input string nm);
        int done_c, last_c, nbad;
        @(negedge clk);
        #1;
        build_model(k);
        done_c = tr.size() + 1;
        g_done = done_c;
        if (drop_c <= 0) drop_c = done_c + 4;
        last_c = (drop_c > done_c) ? drop_c : done_c;
        for (int c = done_c; c <= last_c; c++) tr.push_back(mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b1));
        tr.push_back(mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        last_c++;
        exp_q = tr;
        cyc_in_run = 0;
        rst_n = 1'b1;
        start = 1'b1;
        key   = k;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            #1;
            if (c == drop_c) start = 1'b0;
            if (c == kchg_c) key = k2;
            if (c == rst_c) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                exp_q.delete();
                chk({nm, "_rst_outs"}, {address, ram_in, wren, busy, finished}, 32'h0);
                return;
            end
        end
        nbad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== model_s[n]) nbad++;
        chk({nm, "_final_S_bad_entries"}, nbad, 0);
    endtask

    initial begin
        init_identity();
        #1;
        chk("reset_outs", {address, ram_in, wren, busy, finished}, 32'h0);

        // Identity S, key 0, start held into DONE.
        run(24'h000000, 0, 0, 24'h0, 0, "t_key0");
`ifdef KSA_SKIP_SELF_SWAP_EN
        chk("t_key0_c3_adv",  tr[2],  mk(8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
        chk("t_key0_c6_adv",  tr[5],  mk(8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
        chk("t_key0_c7_rdi",  tr[6],  mk(8'd2, 8'd0, 1'b0, 1'b1, 1'b0));
        chk("t_key0_c11_wri", tr[10], mk(8'd2, 8'd3, 1'b1, 1'b1, 1'b0));
`else
        chk("t_key0_c5_wri",  tr[4],  mk(8'd0, 8'd0, 1'b1, 1'b1, 1'b0));
        chk("t_key0_c11_wri", tr[10], mk(8'd1, 8'd1, 1'b1, 1'b1, 1'b0));
        chk("t_key0_c17_wri", tr[16], mk(8'd2, 8'd3, 1'b1, 1'b1, 1'b0));
        chk("t_key0_c18_wrj", tr[17], mk(8'd3, 8'd2, 1'b1, 1'b1, 1'b0));
        chk("t_key0_done_cycle", g_done, 1537);
`endif
        chk("t_key0_fin_held", tr[g_done+3], mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b1));
        chk("t_key0_idle_after", tr[g_done+4], mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0));

        // Identity S, key 010203, start dropped in cycle 10.
        init_identity();
        run(24'h010203, 10, 0, 24'h0, 0, "t_k123");
        chk("t_k123_c5_wri", tr[4], mk(8'd0, 8'd1, 1'b1, 1'b1, 1'b0));
        chk("t_k123_c6_wrj", tr[5], mk(8'd1, 8'd0, 1'b1, 1'b1, 1'b0));
        chk("t_k123_c9_rdj", tr[8], mk(8'd3, 8'd0, 1'b0, 1'b1, 1'b0));
        chk("t_k123_fin_once", tr[g_done], mk(8'd0, 8'd0, 1'b0, 1'b0, 1'b0));

        // Reset in cycle 700, then a fresh pass over the partially permuted S.
        init_identity();
        run(24'h5a3c91, 5000, 0, 24'h0, 700, "t_rst");
        repeat (3) @(negedge clk);
        #1;
        chk("t_rst_held_outs", {address, ram_in, wren, busy, finished}, 32'h0);
        run(24'h5a3c91, 0, 0, 24'h0, 0, "t_restart");

        // Randomized passes, with key changed mid-run and random start drop.
        for (int r = 0; r < 5; r++) begin
            run(24'($urandom), int'($urandom_range(1, 1560)), int'($urandom_range(2, 1536)),
                24'($urandom), 0, "t_rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
